// File: rtl/add.sv
// Multi-cycle, limb-serial unsigned adder: result = a + b, LIMB bits per cycle.
// Shares the start/done/busy handshake with the multi-cycle subtractor.
module add #(
  parameter int unsigned DATA_WIDTH = 448,
  parameter int unsigned SIZE       = DATA_WIDTH,
  parameter int unsigned LIMB       = 64
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            start,
  input  logic [SIZE-1:0] a,
  input  logic [SIZE-1:0] b,
  output logic [SIZE:0]   result,
  output logic            done,
  output logic            busy
);

  localparam int unsigned NLIMB = SIZE / LIMB;
  localparam int unsigned CntW  = (NLIMB > 1) ? $clog2(NLIMB) : 1;

  if ((SIZE % LIMB) != 0) begin : gen_size_check
    $error("add: SIZE must be an exact multiple of LIMB");
  end

  typedef enum logic [0:0] {StIdle, StRun} state_e;

  state_e            state_q, state_d;
  logic [SIZE-1:0]   a_q, a_d;
  logic [SIZE-1:0]   b_q, b_d;
  logic [SIZE-1:0]   sum_q, sum_d;
  logic              carry_q, carry_d;
  logic [CntW-1:0]   cnt_q, cnt_d;
  logic [SIZE:0]     result_q, result_d;
  logic              done_q, done_d;
  logic [LIMB:0]     s;

  always_comb begin
    s = {1'b0, a_q[LIMB-1:0]} + {1'b0, b_q[LIMB-1:0]} + (LIMB+1)'(carry_q);
  end

  always_comb begin
    state_d  = state_q;
    a_d      = a_q;
    b_d      = b_q;
    sum_d    = sum_q;
    carry_d  = carry_q;
    cnt_d    = cnt_q;
    result_d = result_q;
    done_d   = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (start) begin
          a_d     = a;
          b_d     = b;
          carry_d = 1'b0;
          cnt_d   = '0;
          state_d = StRun;
        end
      end
      StRun: begin
        sum_d[32'(cnt_q)*LIMB +: LIMB] = s[LIMB-1:0];
        carry_d = s[LIMB];
        a_d     = a_q >> LIMB;
        b_d     = b_q >> LIMB;
        cnt_d   = cnt_q + CntW'(1);
        if (cnt_q == CntW'(NLIMB - 1)) begin
          // sum_d already holds the final limb written above
          result_d = {s[LIMB], sum_d};
          done_d   = 1'b1;
          state_d  = StIdle;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= StIdle;
      a_q      <= '0;
      b_q      <= '0;
      sum_q    <= '0;
      carry_q  <= 1'b0;
      cnt_q    <= '0;
      result_q <= '0;
      done_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      a_q      <= a_d;
      b_q      <= b_d;
      sum_q    <= sum_d;
      carry_q  <= carry_d;
      cnt_q    <= cnt_d;
      result_q <= result_d;
      done_q   <= done_d;
    end
  end

  assign result = result_q;
  assign done   = done_q;
  assign busy   = (state_q == StRun);

endmodule

// File: tb/tb_add.sv
// Directed self-checking bench for the limb-serial adder (448-bit, 64-bit limbs).
module tb_add;

  logic         clk;
  logic         rst;
  logic         start;
  logic [447:0] a;
  logic [447:0] b;
  logic [448:0] result;
  logic         done;
  logic         busy;

  int n_checks;
  int n_pass;

  add dut (
    .clk    (clk),
    .rst    (rst),
    .start  (start),
    .a      (a),
    .b      (b),
    .result (result),
    .done   (done),
    .busy   (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // One-cycle start pulse; returns at the negedge after the accepting edge.
  task automatic pulse_start(input logic [447:0] x, input logic [447:0] y);
    @(negedge clk);
    a     = x;
    b     = y;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
  endtask

  // Counts negedges until done is seen (bounded); flags any cycle with busy low before done.
  task automatic wait_done(output int lat, output bit busy_ok);
    lat     = 0;
    busy_ok = 1'b1;
    if (!busy) busy_ok = 1'b0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      lat++;
      if (done) break;
      if (!busy) busy_ok = 1'b0;
    end
  endtask

  task automatic test_reset();
    rst   = 1'b1;
    start = 1'b1;
    a     = 448'd5;
    b     = 448'd3;
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst   = 1'b0;
    start = 1'b0;
    n_checks++;
    if (result !== 449'd0) $display("FAIL reset_result got %h want 0", result);
    else n_pass++;
    n_checks++;
    if ({done, busy} !== 2'b00) $display("FAIL reset_done_busy got %b want 00", {done, busy});
    else n_pass++;
    @(negedge clk);
    n_checks++;
    if (busy !== 1'b0) $display("FAIL reset_start_priority busy got %b want 0", busy);
    else n_pass++;
  endtask

  task automatic test_small();
    int lat;
    bit bok;
    pulse_start(448'd5, 448'd3);
    wait_done(lat, bok);
    n_checks++;
    if (lat !== 7) $display("FAIL small_latency got %0d want 7", lat);
    else n_pass++;
    n_checks++;
    if (bok !== 1'b1) $display("FAIL small_busy got low-during-run want high");
    else n_pass++;
    n_checks++;
    if (result !== 449'h8) $display("FAIL small_result got %h want 8", result);
    else n_pass++;
    n_checks++;
    if (busy !== 1'b0) $display("FAIL small_busy_at_done got %b want 0", busy);
    else n_pass++;
    @(negedge clk);
    n_checks++;
    if (done !== 1'b0) $display("FAIL small_done_width got %b want 0", done);
    else n_pass++;
    n_checks++;
    if (result !== 449'h8) $display("FAIL small_result_hold got %h want 8", result);
    else n_pass++;
  endtask

  task automatic test_full_ripple();
    int lat;
    bit bok;
    logic [448:0] exp;
    exp = {1'b1, 448'd0};
    pulse_start({448{1'b1}}, 448'd1);
    wait_done(lat, bok);
    n_checks++;
    if (lat !== 7 || result !== exp)
      $display("FAIL full_ripple got lat %0d res %h want lat 7 res %h", lat, result, exp);
    else n_pass++;
  endtask

  task automatic test_max_then_zero();
    int lat;
    bit bok;
    logic [448:0] exp;
    exp = {1'b1, {447{1'b1}}, 1'b0};
    pulse_start({448{1'b1}}, {448{1'b1}});
    wait_done(lat, bok);
    n_checks++;
    if (lat !== 7 || result !== exp)
      $display("FAIL max_sum got lat %0d res %h want lat 7 res %h", lat, result, exp);
    else n_pass++;
    pulse_start(448'd0, 448'd0);
    wait_done(lat, bok);
    n_checks++;
    if (lat !== 7 || result !== 449'd0)
      $display("FAIL zero_no_stale_carry got lat %0d res %h want lat 7 res 0", lat, result);
    else n_pass++;
  endtask

  task automatic test_limb_carry_ignore_start();
    int lat;
    bit bok;
    logic [448:0] exp;
    exp = {384'd0, 1'b1, 64'd0};
    pulse_start({384'd0, 64'hFFFF_FFFF_FFFF_FFFF}, 448'd1);
    @(negedge clk);
    @(negedge clk);
    a     = {448{1'b1}};
    b     = {448{1'b1}};
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    n_checks++;
    if (busy !== 1'b1 || done !== 1'b0)
      $display("FAIL mid_run_start busy/done got %b%b want 10", busy, done);
    else n_pass++;
    wait_done(lat, bok);
    n_checks++;
    if (lat + 3 !== 7 || result !== exp)
      $display("FAIL limb_carry got lat %0d res %h want lat 7 res %h", lat + 3, result, exp);
    else n_pass++;
    @(negedge clk);
    n_checks++;
    if (busy !== 1'b0 || done !== 1'b0)
      $display("FAIL ignored_start_not_queued busy/done got %b%b want 00", busy, done);
    else n_pass++;
  endtask

  task automatic test_reset_abort();
    int lat;
    int n_done;
    bit bok;
    pulse_start(448'd5, 448'd3);
    @(negedge clk);
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    n_checks++;
    if (result !== 449'd0 || busy !== 1'b0 || done !== 1'b0)
      $display("FAIL abort_state got res %h busy %b done %b want 0 0 0", result, busy, done);
    else n_pass++;
    n_done = 0;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      if (done) n_done++;
    end
    n_checks++;
    if (n_done !== 0) $display("FAIL abort_no_done got %0d pulses want 0", n_done);
    else n_pass++;
    pulse_start(448'd2, 448'd2);
    wait_done(lat, bok);
    n_checks++;
    if (lat !== 7 || result !== 449'd4)
      $display("FAIL after_abort got lat %0d res %h want lat 7 res 4", lat, result);
    else n_pass++;
  endtask

  task automatic test_back_to_back();
    int lat;
    bit bok;
    pulse_start(448'd1, 448'd1);
    wait_done(lat, bok);
    n_checks++;
    if (lat !== 7 || result !== 449'd2)
      $display("FAIL b2b_first got lat %0d res %h want lat 7 res 2", lat, result);
    else n_pass++;
    // start during the done cycle
    a     = 448'd10;
    b     = 448'd20;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    n_checks++;
    if (busy !== 1'b1 || done !== 1'b0 || result !== 449'd2)
      $display("FAIL b2b_accept got busy %b done %b res %h want 1 0 2", busy, done, result);
    else n_pass++;
    wait_done(lat, bok);
    n_checks++;
    if (lat !== 7 || result !== 449'd30 || bok !== 1'b1)
      $display("FAIL b2b_second got lat %0d res %h busy_ok %b want lat 7 res 1e 1",
               lat, result, bok);
    else n_pass++;
  endtask

  initial begin
    n_checks = 0;
    n_pass   = 0;
    rst      = 1'b1;
    start    = 1'b0;
    a        = '0;
    b        = '0;
    test_reset();
    test_small();
    test_full_ripple();
    test_max_then_zero();
    test_limb_carry_ignore_start();
    test_reset_abort();
    test_back_to_back();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
